ahb_sram_slave: RTL

AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

---
 rtl/ahb_pkg.sv | 43 ++++
 rtl/ahb_byte_ram.sv | 34 +++
 rtl/ahb_sram_slave.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// ============================================================================
// Module  : ahb_pkg
// Brief   : Shared AHB-Lite encodings, slave FSM states and byte-lane helper.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ahb_pkg;

    localparam logic [1:0] c_HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] c_HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] c_HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] c_HTRANS_SEQ    = 2'd3;

    localparam logic [2:0] c_HSIZE_BYTE = 3'd0;
    localparam logic [2:0] c_HSIZE_HALF = 3'd1;
    localparam logic [2:0] c_HSIZE_WORD = 3'd2;

    localparam logic c_HRESP_OKAY  = 1'b0;
    localparam logic c_HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DONE = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } ahb_state_e;

    // Little-endian lane enables; only called with sizes already checked legal.
    function automatic logic [3:0] f_byte_en(input logic [2:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            c_HSIZE_BYTE: be = 4'b0001 << off;
            c_HSIZE_HALF: be = off[1] ? 4'b1100 : 4'b0011;
            default:      be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ahb_byte_ram.sv
// ============================================================================
// Module  : ahb_byte_ram
// Brief   : 32-bit word RAM with per-byte write enable and asynchronous read.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_byte_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [3:0]    i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (i_we[b]) begin
                r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/ahb_sram_slave.sv
// ============================================================================
// Module  : ahb_sram_slave
// Brief   : AHB-Lite SRAM slave with configurable wait states and error checks.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic [2:0]  hsize,
    input  logic        hwrite,
    input  logic [2:0]  hburst,
    input  logic [6:0]  hprot,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic        hreadyout,
    output logic        hresp,
    output logic [31:0] hrdata
);

    localparam int          c_AW        = $clog2(MEM_DEPTH);
    localparam logic [31:0] c_DEPTH     = 32'(MEM_DEPTH);
    localparam logic [3:0]  c_WCNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    ahb_state_e      r_state;
    ahb_state_e      w_state_nxt;
    logic [3:0]      r_wcnt;
    logic [c_AW+1:0] r_addr;
    logic [2:0]      r_size;
    logic            r_write;

    logic            w_slot;
    logic            w_accept;
    logic            w_err;
    logic [3:0]      w_we;
    logic [31:0]     w_rdata;
    logic            w_unused;

    assign w_unused = ^{hburst, hprot};

    // A new address phase may only land when the previous data phase is ending.
    assign w_slot   = (r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR2);
    assign w_accept = w_slot && hsel && hready &&
                      ((htrans == c_HTRANS_NONSEQ) || (htrans == c_HTRANS_SEQ));

    assign w_err = (hsize > c_HSIZE_WORD) ||
                   ((hsize == c_HSIZE_HALF) && haddr[0]) ||
                   ((hsize == c_HSIZE_WORD) && (haddr[1:0] != 2'b00)) ||
                   ({2'b00, haddr[31:2]} >= c_DEPTH);

    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_WAIT: begin
                if (r_wcnt == 4'd0) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_ERR1: w_state_nxt = ST_ERR2;
            default: begin
                if (!w_accept) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_err) begin
                    w_state_nxt = ST_ERR1;
                end else if (WAIT_STATES > 0) begin
                    w_state_nxt = ST_WAIT;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
        endcase
    end

    always_comb begin
        hreadyout = 1'b1;
        hresp     = c_HRESP_OKAY;
        hrdata    = 32'd0;
        case (r_state)
            ST_WAIT: hreadyout = 1'b0;
            ST_ERR1: begin
                hreadyout = 1'b0;
                hresp     = c_HRESP_ERROR;
            end
            ST_ERR2: hresp = c_HRESP_ERROR;
            ST_DONE: begin
                if (!r_write) begin
                    hrdata = w_rdata;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_wcnt  <= 4'd0;
            r_addr  <= '0;
            r_size  <= 3'd0;
            r_write <= 1'b0;
        end else if (w_accept) begin
            r_wcnt  <= c_WCNT_INIT;
            r_addr  <= haddr[c_AW+1:0];
            r_size  <= hsize;
            r_write <= hwrite;
        end else if ((r_state == ST_WAIT) && (r_wcnt != 4'd0)) begin
            r_wcnt <= r_wcnt - 4'd1;
        end
    end

    // Commit only on the completing edge; a reset on that edge abandons it.
    assign w_we = ((r_state == ST_DONE) && r_write && !hreset) ?
                  f_byte_en(r_size, r_addr[1:0]) : 4'b0000;

    ahb_byte_ram #(
        .DEPTH (MEM_DEPTH),
        .AW    (c_AW)
    ) u_ram (
        .clk     (hclk),
        .i_we    (w_we),
        .i_waddr (r_addr[c_AW+1:2]),
        .i_wdata (hwdata),
        .i_raddr (r_addr[c_AW+1:2]),
        .o_rdata (w_rdata)
    );

endmodule

`default_nettype wire
